// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Holds the FSM state codes, the channel owner codes and the default access timeout.
package mem_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_BUSY_I = 3'd1;
    localparam state_t ST_BUSY_D = 3'd2;
    localparam state_t ST_RESP_I = 3'd3;
    localparam state_t ST_RESP_D = 3'd4;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker: combinational choice between fetch and load/store,
// with the last granted owner held in a register and advanced only when a grant is taken.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RES,
    input  logic instr_req,
    input  logic data_req,
    input  logic advance,
    output logic grant,
    output logic owner
);

    logic last_owner;

    always_comb begin
        grant = instr_req | data_req;
        if (instr_req && data_req) begin
            owner = ~last_owner;
        end else if (data_req) begin
            owner = OWNER_DATA;
        end else begin
            owner = OWNER_INSTR;
        end
    end

    // Resetting to INSTR makes the first tie go to the data channel.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            last_owner <= OWNER_INSTR;
        end else if (advance && grant) begin
            last_owner <= owner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port memory.
// state   | meaning
// IDLE    | no access in flight, arbitrate pending requests
// BUSY_I  | fetch issued, waiting for mem_valid or timeout
// BUSY_D  | load/store issued, waiting for mem_valid or timeout
// RESP_I  | instr_valid pulse, back to IDLE next cycle
// RESP_D  | data_valid pulse, back to IDLE next cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADR_W       = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              instr_req,
    input  logic [ADR_W-1:0]  instr_adr,
    output logic [DATA_W-1:0] instr_read,
    output logic              instr_valid,
    input  logic              data_req,
    input  logic              data_write_enable,
    input  logic [ADR_W-1:0]  data_adr,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] data_read,
    output logic              data_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant;
    logic             owner;
    logic             in_idle;

    assign in_idle     = (state == ST_IDLE);
    assign instr_valid = (state == ST_RESP_I);
    assign data_valid  = (state == ST_RESP_D);

    arb_rr2 u_arb (
        .CLK       (CLK),
        .RES       (RES),
        .instr_req (instr_req),
        .data_req  (data_req),
        .advance   (in_idle),
        .grant     (grant),
        .owner     (owner)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_adr     <= '0;
            mem_wdata   <= '0;
            instr_read  <= '0;
            data_read   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        if (owner == OWNER_DATA) begin
                            state     <= ST_BUSY_D;
                            mem_we    <= data_write_enable;
                            mem_adr   <= data_adr;
                            mem_wdata <= data_write;
                        end else begin
                            state     <= ST_BUSY_I;
                            mem_we    <= 1'b0;
                            mem_adr   <= instr_adr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // A completion in the terminal cycle takes priority over the abort.
                    if (mem_valid) begin
                        mem_req <= 1'b0;
                        if (state == ST_BUSY_D) begin
                            data_read <= mem_rdata;
                            state     <= ST_RESP_D;
                        end else begin
                            instr_read <= mem_rdata;
                            state      <= ST_RESP_I;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) begin
                            mem_req     <= 1'b0;
                            timeout_err <= 1'b1;
                            if (state == ST_BUSY_D) begin
                                data_read <= '0;
                                state     <= ST_RESP_D;
                            end else begin
                                instr_read <= '0;
                                state      <= ST_RESP_I;
                            end
                        end
                    end
                end
                ST_RESP_I, ST_RESP_D: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory issues and responses are queued
// by the stimulus and consumed by a monitor that watches mem_req and the valid pulses.
module tb_mem_arbiter;

    localparam int ADR_W  = 32;
    localparam int DATA_W = 32;
    localparam int TO_CYC = 4;

    logic              CLK = 1'b0;
    logic              RES = 1'b1;
    logic              instr_req = 1'b0;
    logic [ADR_W-1:0]  instr_adr = '0;
    logic [DATA_W-1:0] instr_read;
    logic              instr_valid;
    logic              data_req = 1'b0;
    logic              data_write_enable = 1'b0;
    logic [ADR_W-1:0]  data_adr = '0;
    logic [DATA_W-1:0] data_write = '0;
    logic [DATA_W-1:0] data_read;
    logic              data_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              timeout_err;

    logic              mem_manual   = 1'b0;
    logic              manual_valid = 1'b0;
    logic              model_valid  = 1'b0;
    logic [DATA_W-1:0] model_rdata  = '0;
    int                mem_wait     = 0;
    int                mem_cnt      = 0;

    assign mem_valid = mem_manual ? manual_valid : model_valid;
    assign mem_rdata = mem_manual ? 32'hFFFF_FFFF : model_rdata;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADR_W       (ADR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK               (CLK),
        .RES               (RES),
        .instr_req         (instr_req),
        .instr_adr         (instr_adr),
        .instr_read        (instr_read),
        .instr_valid       (instr_valid),
        .data_req          (data_req),
        .data_write_enable (data_write_enable),
        .data_adr          (data_adr),
        .data_write        (data_write),
        .data_read         (data_read),
        .data_valid        (data_valid),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_adr           (mem_adr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_valid         (mem_valid),
        .timeout_err       (timeout_err)
    );

    typedef struct {
        logic        ch;
        logic [31:0] rdata;
        logic        chk_rd;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          len;
    } memx_t;

    resp_t       exp_resp[$];
    memx_t       exp_mem[$];
    logic [31:0] mem_data_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Memory responder: answers after mem_wait cycles of mem_req, data taken in issue order.
    initial begin
        forever begin
            @(negedge CLK);
            if (mem_manual || RES) begin
                mem_cnt     = 0;
                model_valid = 1'b0;
            end else if (model_valid) begin
                model_valid = 1'b0;
                mem_cnt     = 0;
            end else if (mem_req) begin
                if (mem_cnt >= mem_wait) begin
                    model_valid = 1'b1;
                    if (mem_data_q.size() > 0) model_rdata = mem_data_q.pop_front();
                    else model_rdata = 32'h0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    resp_t       mon_r;
    memx_t       mon_m;
    logic        prev_valid   = 1'b0;
    logic        prev_mem_req = 1'b0;
    logic        stable_ok    = 1'b1;
    int          cur_len      = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RES) begin
                prev_valid   = 1'b0;
                prev_mem_req = 1'b0;
            end else begin
                if (instr_valid || data_valid) begin
                    chk("valid_pulse_width", 32'(prev_valid), 32'd0);
                    chk("valid_exclusive", 32'(instr_valid & data_valid), 32'd0);
                    if (exp_resp.size() == 0) begin
                        chk("unexpected_valid", 32'({instr_valid, data_valid}), 32'd0);
                    end else begin
                        mon_r = exp_resp.pop_front();
                        chk("resp_channel", 32'(data_valid), 32'(mon_r.ch));
                        if (mon_r.chk_rd) begin
                            if (mon_r.ch) chk("data_read", data_read, mon_r.rdata);
                            else chk("instr_read", instr_read, mon_r.rdata);
                        end
                    end
                end
                if (mem_req && !prev_mem_req) begin
                    if (exp_mem.size() == 0) begin
                        chk("unexpected_mem_req", 32'(mem_req), 32'd0);
                    end else begin
                        mon_m = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(mon_m.we));
                        chk("mem_adr", mem_adr, mon_m.adr);
                        if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.wdata);
                        cur_len   = 1;
                        stable_ok = 1'b1;
                    end
                end else if (mem_req) begin
                    cur_len++;
                    if (mem_adr !== mon_m.adr || mem_we !== mon_m.we) stable_ok = 1'b0;
                end else if (prev_mem_req) begin
                    chk("mem_stable", 32'(stable_ok), 32'd1);
                    if (mon_m.len >= 0) chk("mem_req_len", cur_len, mon_m.len);
                end
                prev_valid   = instr_valid | data_valid;
                prev_mem_req = mem_req;
            end
        end
    end

    task automatic push_instr(input logic [31:0] adr, input logic [31:0] rdata, input int len,
                              input bit with_data);
        exp_mem.push_back('{we: 1'b0, adr: adr, wdata: 32'h0, len: len});
        if (with_data) mem_data_q.push_back(rdata);
        exp_resp.push_back('{ch: 1'b0, rdata: rdata, chk_rd: 1'b1});
    endtask

    task automatic push_data(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int len);
        exp_mem.push_back('{we: we, adr: adr, wdata: wdata, len: len});
        mem_data_q.push_back(rdata);
        exp_resp.push_back('{ch: 1'b1, rdata: rdata, chk_rd: !we});
    endtask

    task automatic instr_access(input logic [31:0] adr, input logic [31:0] late_adr, input bit move,
                                output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        instr_adr = adr;
        instr_req = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (move && mem_req) instr_adr = late_adr;
            if (instr_valid) got = 1'b1;
        end
        chk("instr_done", 32'(got), 32'd1);
        instr_req = 1'b0;
    endtask

    task automatic data_access(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                               output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        data_write_enable = we;
        data_adr          = adr;
        data_write        = wdata;
        data_req          = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (data_valid) got = 1'b1;
        end
        chk("data_done", 32'(got), 32'd1);
        data_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat_i, lat_d;

    initial begin
        @(negedge CLK);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_instr_read", instr_read, 32'd0);
        chk("rst_data_read", data_read, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);

        mem_wait = 2;
        push_instr(32'h40, 32'h0050_0093, 3, 1'b1);
        instr_access(32'h40, 32'h0, 1'b0, lat_i);
        chk("fetch_latency", lat_i, 32'd4);
        @(negedge CLK);

        mem_wait = 1;
        push_data(1'b0, 32'h300, 32'h0, 32'h1111_2222, 2);
        push_instr(32'h44, 32'h3333_4444, 2, 1'b1);
        fork
            instr_access(32'h44, 32'h0, 1'b0, lat_i);
            data_access(1'b0, 32'h300, 32'h0, lat_d);
        join
        chk("tie1_data_latency", lat_d, 32'd3);
        chk("tie1_instr_latency", lat_i, 32'd7);
        @(negedge CLK);

        mem_wait = 0;
        push_data(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1);
        data_access(1'b1, 32'h100, 32'hDEAD_BEEF, lat_d);
        chk("store_latency", lat_d, 32'd2);
        @(negedge CLK);

        push_instr(32'h48, 32'hAAAA_0001, 1, 1'b1);
        push_data(1'b1, 32'h104, 32'h0BAD_F00D, 32'h0, 1);
        fork
            instr_access(32'h48, 32'h0, 1'b0, lat_i);
            data_access(1'b1, 32'h104, 32'h0BAD_F00D, lat_d);
        join
        chk("tie2_instr_latency", lat_i, 32'd2);
        chk("tie2_data_latency", lat_d, 32'd5);
        @(negedge CLK);

        mem_wait = 3;
        push_instr(32'h40, 32'h55AA_55AA, 4, 1'b1);
        instr_access(32'h40, 32'h80, 1'b1, lat_i);
        chk("adr_change_latency", lat_i, 32'd5);
        chk("timeout_err_clear", 32'(timeout_err), 32'd0);
        @(negedge CLK);

        mem_manual   = 1'b1;
        manual_valid = 1'b0;
        push_instr(32'h60, 32'h0, TO_CYC, 1'b0);
        instr_access(32'h60, 32'h0, 1'b0, lat_i);
        chk("timeout_latency", lat_i, 32'd5);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        mem_manual = 1'b0;
        @(negedge CLK);

        mem_wait = 1;
        push_data(1'b0, 32'h204, 32'h0, 32'h1234_5678, 2);
        data_access(1'b0, 32'h204, 32'h0, lat_d);
        chk("load_after_timeout_latency", lat_d, 32'd3);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        chk("instr_read_hold", instr_read, 32'h0);
        @(negedge CLK);

        mem_manual   = 1'b1;
        manual_valid = 1'b0;
        exp_mem.push_back('{we: 1'b1, adr: 32'h208, wdata: 32'hCAFE_F00D, len: -1});
        data_write_enable = 1'b1;
        data_adr          = 32'h208;
        data_write        = 32'hCAFE_F00D;
        data_req          = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("busy_before_reset", 32'(mem_req), 32'd1);
        #2 RES = 1'b1;
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_data_valid", 32'(data_valid), 32'd0);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge CLK);
        data_req = 1'b0;
        @(negedge CLK);
        #2 RES = 1'b0;
        @(negedge CLK);
        manual_valid = 1'b1;
        @(negedge CLK);
        manual_valid = 1'b0;
        chk("late_valid_mem_req", 32'(mem_req), 32'd0);
        @(negedge CLK);
        chk("late_valid_data_read", data_read, 32'h0);
        chk("late_valid_idle", 32'(mem_req | data_valid | instr_valid), 32'd0);
        mem_manual = 1'b0;

        mem_wait = 0;
        push_data(1'b0, 32'h30C, 32'h0, 32'h0F0F_0F0F, 1);
        push_instr(32'h4C, 32'h7777_8888, 1, 1'b1);
        fork
            instr_access(32'h4C, 32'h0, 1'b0, lat_i);
            data_access(1'b0, 32'h30C, 32'h0, lat_d);
        join
        chk("tie3_data_latency", lat_d, 32'd2);
        chk("tie3_instr_latency", lat_i, 32'd5);

        repeat (3) @(negedge CLK);
        chk("exp_resp_drained", exp_resp.size(), 32'd0);
        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
